// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;
  typedef enum logic {NORMAL = 1'b0, STALL = 1'b1} state_e;

  localparam logic [1:0] REQ_WB  = 2'd0;
  localparam logic [1:0] REQ_MDU = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int CNT_W            = 4;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back, MDU and debug write requests in; register-file write port and stall out.
interface regfile_write_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              stall_pipe;

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  mdu_valid, mdu_addr, mdu_data,
    input  dbg_valid, dbg_addr, dbg_data,
    output mdu_ready, dbg_ready,
    output rf_we, rf_addr, rf_data, stall_pipe
  );

  modport master (
    output wb_we, wb_addr, wb_data,
    output mdu_valid, mdu_addr, mdu_data,
    output dbg_valid, dbg_addr, dbg_data,
    input  mdu_ready, dbg_ready,
    input  rf_we, rf_addr, rf_data, stall_pipe
  );
endinterface

// File: rtl/regfile_write_arbiter_starve_counter.sv
// Saturating denied-cycle counter; hit flags that the count reaches LIMIT at this edge.
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                cnt_d = '0;
    else if (inc && cnt_q != CNT_W'(LIMIT)) cnt_d = cnt_q + 1'b1;
  end

  // Looking at the next value lets the stall land in the cycle right after the limit is reached.
  assign hit = (cnt_d == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by write-back (priority), MDU and debug.
module regfile_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_write_arbiter_if.slave   bus
);
  // Secondary requesters as packed vectors: bit 0 = MDU, bit 1 = DBG.
  logic [1:0]        sec_vld, sec_gnt, sec_hit;
  logic              wb_gnt, any_gnt;
  state_e            state_q, state_d;
  logic [1:0]        victim_q, victim_d;
  logic [ADDR_W-1:0] sel_addr, rf_addr_q;
  logic [DATA_W-1:0] sel_data, rf_data_q;
  logic              rf_we_q;

  assign sec_vld = {bus.dbg_valid, bus.mdu_valid};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    starve_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (sec_vld[g] & ~sec_gnt[g]),
      .clr (sec_gnt[g] | ~sec_vld[g]),
      .hit (sec_hit[g])
    );
  end

  // Grants are combinational; held off during reset so ready reads 0.
  always_comb begin
    wb_gnt  = 1'b0;
    sec_gnt = '0;
    if (!rst) begin
      if (state_q == STALL) begin
        sec_gnt[0] = sec_vld[0] & (victim_q == REQ_MDU);
        sec_gnt[1] = sec_vld[1] & (victim_q == REQ_DBG);
      end else if (bus.wb_we)  wb_gnt     = 1'b1;
      else if (sec_vld[0])     sec_gnt[0] = 1'b1;
      else                     sec_gnt[1] = sec_vld[1];
    end
  end

  always_comb begin
    state_d  = NORMAL;
    victim_d = victim_q;
    if (state_q == NORMAL && |sec_hit) begin
      state_d  = STALL;
      victim_d = sec_hit[0] ? REQ_MDU : REQ_DBG;
    end
  end

  always_comb begin
    sel_addr = bus.wb_addr;
    sel_data = bus.wb_data;
    if (sec_gnt[0]) begin
      sel_addr = bus.mdu_addr;
      sel_data = bus.mdu_data;
    end else if (sec_gnt[1]) begin
      sel_addr = bus.dbg_addr;
      sel_data = bus.dbg_data;
    end
  end

  assign any_gnt = wb_gnt | (|sec_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      victim_q  <= REQ_MDU;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      // r0 writes complete the handshake but never reach the register file.
      rf_we_q  <= any_gnt && (sel_addr != '0);
      if (any_gnt) begin
        rf_addr_q <= sel_addr;
        rf_data_q <= sel_data;
      end
    end
  end

  assign bus.mdu_ready  = sec_gnt[0];
  assign bus.dbg_ready  = sec_gnt[1];
  assign bus.stall_pipe = (state_q == STALL);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_data    = rf_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic checked against a denied-count reference model.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mdu_valid = 0; bus.mdu_addr = '0; bus.mdu_data = '0;
    bus.dbg_valid = 0; bus.dbg_addr = '0; bus.dbg_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    n_cmp++;
    if ({bus.rf_we, bus.stall_pipe, bus.mdu_ready, bus.dbg_ready} !== 4'b0 || bus.rf_addr !== '0 || bus.rf_data !== '0) begin
      n_err++; $display("FAIL reset_init: we=%b stall=%b addr=%h data=%h, need all 0", bus.rf_we, bus.stall_pipe, bus.rf_addr, bus.rf_data);
    end
    @(negedge clk) rst = 0;
    @(posedge clk) #1;
    bus.wb_we = 1; bus.wb_addr = 5'd8; bus.wb_data = 32'd5;
    @(posedge clk) #1;
    n_cmp++;
    if (bus.rf_we !== 1'b1) begin n_err++; $display("FAIL reset_pre_we: rf_we=%b need 1", bus.rf_we); end
    bus.wb_we = 0;
    bus.mdu_valid = 1; bus.mdu_addr = 5'd3; bus.mdu_data = 32'd7;
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({bus.rf_we, bus.stall_pipe, bus.mdu_ready, bus.dbg_ready} !== 4'b0 || bus.rf_addr !== '0 || bus.rf_data !== '0) begin
      n_err++; $display("FAIL reset_mid: we=%b stall=%b mrdy=%b addr=%h data=%h, need all 0", bus.rf_we, bus.stall_pipe, bus.mdu_ready, bus.rf_addr, bus.rf_data);
    end
    @(negedge clk) rst = 0;
    #1;
    n_cmp++;
    if (bus.mdu_ready !== 1'b1 || bus.stall_pipe !== 1'b0) begin
      n_err++; $display("FAIL reset_rearb: mdu_ready=%b stall=%b, need 1/0", bus.mdu_ready, bus.stall_pipe);
    end
    @(posedge clk) #1;
    bus.mdu_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd3 || bus.rf_data !== 32'd7) begin
      n_err++; $display("FAIL reset_rearb_wr: we=%b addr=%h data=%h, need 1/03/7", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
  endtask

  task automatic test_plain_wb();
    bus.wb_we = 1; bus.wb_addr = 5'd8; bus.wb_data = 32'd5;
    @(posedge clk) #1;
    bus.wb_we = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd8 || bus.rf_data !== 32'd5) begin
      n_err++; $display("FAIL plain_wb: we=%b addr=%h data=%h, need 1/08/5", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
    @(posedge clk) #1;
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL plain_wb_once: rf_we=%b need 0", bus.rf_we); end
  endtask

  task automatic test_idle_mdu();
    bus.mdu_valid = 1; bus.mdu_addr = 5'd3; bus.mdu_data = 32'hDEAD;
    #1;
    n_cmp++;
    if (bus.mdu_ready !== 1'b1) begin n_err++; $display("FAIL idle_mdu_rdy: mdu_ready=%b need 1", bus.mdu_ready); end
    @(posedge clk) #1;
    bus.mdu_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd3 || bus.rf_data !== 32'hDEAD) begin
      n_err++; $display("FAIL idle_mdu_wr: we=%b addr=%h data=%h, need 1/03/dead", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
  endtask

  task automatic test_starvation();
    bus.mdu_valid = 1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h1234_5678;
    for (int c = 1; c <= SL; c++) begin
      bus.wb_we = 1; bus.wb_addr = 5'(10 + c); bus.wb_data = 32'(100 + c);
      @(negedge clk);
      n_cmp++;
      if (bus.mdu_ready !== 1'b0 || bus.stall_pipe !== 1'b0) begin
        n_err++; $display("FAIL starve_deny c%0d: mdu_ready=%b stall=%b, need 0/0", c, bus.mdu_ready, bus.stall_pipe);
      end
      @(posedge clk) #1;
    end
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'(10 + SL) || bus.rf_data !== 32'(100 + SL)) begin
      n_err++; $display("FAIL starve_prev_wb: we=%b addr=%h data=%0d, need wb #%0d", bus.rf_we, bus.rf_addr, bus.rf_data, SL);
    end
    bus.wb_addr = 5'(11 + SL); bus.wb_data = 32'(101 + SL);
    @(negedge clk);
    n_cmp++;
    if (bus.stall_pipe !== 1'b1 || bus.mdu_ready !== 1'b1) begin
      n_err++; $display("FAIL starve_stall: stall=%b mdu_ready=%b, need 1/1", bus.stall_pipe, bus.mdu_ready);
    end
    @(posedge clk) #1;
    bus.mdu_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd9 || bus.rf_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL starve_mdu_wr: we=%b addr=%h data=%h, need 1/09/12345678", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.stall_pipe !== 1'b0) begin n_err++; $display("FAIL starve_unstall: stall=%b need 0", bus.stall_pipe); end
    @(posedge clk) #1;
    bus.wb_we = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'(11 + SL) || bus.rf_data !== 32'(101 + SL)) begin
      n_err++; $display("FAIL starve_held_wb: we=%b addr=%h data=%0d, need held wb", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_both_starved();
    int mc_at = -1, dc_at = -1;
    bit mw = 0, dw = 0, hold = 0, gm, gd;
    bus.mdu_valid = 1; bus.mdu_addr = 5'd17; bus.mdu_data = 32'hAAAA;
    bus.dbg_valid = 1; bus.dbg_addr = 5'd18; bus.dbg_data = 32'hBBBB;
    for (int c = 1; c <= 20; c++) begin
      if (!hold) begin bus.wb_we = 1; bus.wb_addr = 5'(1 + c % 8); bus.wb_data = 32'(c); end
      @(negedge clk);
      gm = bus.mdu_ready; gd = bus.dbg_ready; hold = bus.stall_pipe;
      if (gm && mc_at < 0) mc_at = c;
      if (gd && dc_at < 0) dc_at = c;
      @(posedge clk) #1;
      if (bus.rf_we && bus.rf_addr == 5'd17 && bus.rf_data == 32'hAAAA) mw = 1;
      if (bus.rf_we && bus.rf_addr == 5'd18 && bus.rf_data == 32'hBBBB) dw = 1;
      if (gm) bus.mdu_valid = 0;
      if (gd) bus.dbg_valid = 0;
    end
    bus.wb_we = 0;
    n_cmp++;
    if (mc_at != SL + 1) begin n_err++; $display("FAIL both_mdu_cycle: granted in %0d need %0d", mc_at, SL + 1); end
    n_cmp++;
    if (dc_at != SL + 3) begin n_err++; $display("FAIL both_dbg_cycle: granted in %0d need %0d", dc_at, SL + 3); end
    n_cmp++;
    if (!mw || !dw) begin n_err++; $display("FAIL both_writes: mdu_written=%0d dbg_written=%0d need 1/1", mw, dw); end
    @(posedge clk) #1;
  endtask

  task automatic test_r0();
    bus.dbg_valid = 1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'hFF;
    #1;
    n_cmp++;
    if (bus.dbg_ready !== 1'b1) begin n_err++; $display("FAIL r0_rdy: dbg_ready=%b need 1", bus.dbg_ready); end
    @(posedge clk) #1;
    bus.dbg_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL r0_drop: rf_we=%b need 0", bus.rf_we); end
  endtask

  // Reference: integer denied counts per secondary; a count reaching the limit
  // buys the next cycle as a stall granted to that requester (MDU first).
  task automatic test_random(input int n);
    int mc = 0, dc = 0, vic = 0;
    bit stl = 0, was_stl = 0, nstl, gw, gm, gd, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      if (!was_stl) begin
        bus.wb_we = ($urandom_range(0, 99) < 70); bus.wb_addr = 5'($urandom_range(0, 7)); bus.wb_data = $urandom;
      end
      if (!bus.mdu_valid && $urandom_range(0, 2) == 0) begin
        bus.mdu_valid = 1; bus.mdu_addr = 5'($urandom_range(0, 7)); bus.mdu_data = $urandom;
      end
      if (!bus.dbg_valid && $urandom_range(0, 2) == 0) begin
        bus.dbg_valid = 1; bus.dbg_addr = 5'($urandom_range(0, 7)); bus.dbg_data = $urandom;
      end
      gw = 0; gm = 0; gd = 0;
      if (stl) begin gm = (vic == 1); gd = (vic == 2); end
      else if (bus.wb_we) gw = 1;
      else if (bus.mdu_valid) gm = 1;
      else if (bus.dbg_valid) gd = 1;
      ea = gw ? bus.wb_addr : gm ? bus.mdu_addr : bus.dbg_addr;
      ed = gw ? bus.wb_data : gm ? bus.mdu_data : bus.dbg_data;
      ew = (gw | gm | gd) && (ea != 0);
      @(negedge clk);
      n_cmp++;
      if ({bus.mdu_ready, bus.dbg_ready, bus.stall_pipe} !== {gm, gd, stl}) begin
        n_err++; $display("FAIL rand_hs i%0d: mrdy/drdy/stall=%b%b%b need %b%b%b", i, bus.mdu_ready, bus.dbg_ready, bus.stall_pipe, gm, gd, stl);
      end
      mc = (bus.mdu_valid && !gm) ? ((mc < SL) ? mc + 1 : SL) : 0;
      dc = (bus.dbg_valid && !gd) ? ((dc < SL) ? dc + 1 : SL) : 0;
      nstl = !stl && (mc == SL || dc == SL);
      if (nstl) vic = (mc == SL) ? 1 : 2;
      @(posedge clk) #1;
      n_cmp++;
      if (bus.rf_we !== ew || (ew && (bus.rf_addr !== ea || bus.rf_data !== ed))) begin
        n_err++; $display("FAIL rand_wr i%0d: we=%b addr=%h data=%h need we=%b addr=%h data=%h", i, bus.rf_we, bus.rf_addr, bus.rf_data, ew, ea, ed);
      end
      if (gm) bus.mdu_valid = 0;
      if (gd) bus.dbg_valid = 0;
      was_stl = stl; stl = nstl;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_plain_wb();
    test_idle_mdu();
    test_starvation();
    test_both_starved();
    test_r0();
    @(posedge clk) #1;
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
